// File: rtl/hs_io_port.sv
// FIFO-buffered device I/O port: four-phase active-low handshakes to the input and
// output devices, DEPTH-entry RX/TX FIFOs to the core. Optional HS_IO_TIMEOUT_EN adds stall timeouts.
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a device request while RX has room
//   RX_ACK   | word captured, ack low, waiting for the request to release
// TX FSM
//   state    | meaning
//   TX_IDLE  | waiting for a device request while TX holds data
//   TX_PRES  | head word on output_bus, rdy low, waiting for the device ack
//   TX_DONE  | word popped, waiting for request and ack to both release
module hs_io_port #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                       g_clk,
   input  logic                       g_clr,
   input  logic [DATA_W-1:0]          input_bus,
   input  logic                       in_dev_hs,
   output logic                       in_dev_ack,
   output logic [DATA_W-1:0]          output_bus,
   input  logic                       out_dev_hs,
   output logic                       out_dev_rdy,
   input  logic                       out_dev_ack,
   input  logic                       rx_rd,
   output logic [DATA_W-1:0]          rx_data,
   output logic                       rx_empty,
   output logic [$clog2(DEPTH):0]     rx_count,
   input  logic                       tx_wr,
   input  logic [DATA_W-1:0]          tx_data,
   output logic                       tx_full,
   output logic [$clog2(DEPTH):0]     tx_count,
   input  logic                       err_clr,
   output logic                       err_rx_to,
   output logic                       err_tx_to
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {RX_IDLE, RX_ACK} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_PRES, TX_DONE} tx_state_t;

   logic [1:0]        r_in_hs_sync, r_out_hs_sync, r_out_ack_sync;
   logic              w_in_hs_s, w_out_hs_s, w_out_ack_s;

   logic [DATA_W-1:0] r_rx_mem [DEPTH];
   logic [AW-1:0]     r_rx_wp, r_rx_rp;
   logic [CW-1:0]     r_rx_cnt;
   logic              w_rx_full, w_rx_push, w_rx_pop;

   logic [DATA_W-1:0] r_tx_mem [DEPTH];
   logic [AW-1:0]     r_tx_wp, r_tx_rp;
   logic [CW-1:0]     r_tx_cnt;
   logic              w_tx_full, w_tx_push, w_tx_pop, w_tx_load;

   rx_state_t         r_rx_st, w_rx_nxt;
   tx_state_t         r_tx_st, w_tx_nxt;
   logic              r_in_ack, w_in_ack_nxt;
   logic              r_out_rdy, w_out_rdy_nxt;
   logic [DATA_W-1:0] r_out_bus;
   logic              w_rx_tmo, w_tx_tmo;

   // Device strobes are asynchronous; idle level is high so the syncs reset to 1.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_in_hs_sync   <= 2'b11;
         r_out_hs_sync  <= 2'b11;
         r_out_ack_sync <= 2'b11;
      end else begin
         r_in_hs_sync   <= {r_in_hs_sync[0], in_dev_hs};
         r_out_hs_sync  <= {r_out_hs_sync[0], out_dev_hs};
         r_out_ack_sync <= {r_out_ack_sync[0], out_dev_ack};
      end
   end

   assign w_in_hs_s   = r_in_hs_sync[1];
   assign w_out_hs_s  = r_out_hs_sync[1];
   assign w_out_ack_s = r_out_ack_sync[1];

   // RX FIFO: device pushes, core pops.
   assign w_rx_full = (r_rx_cnt == CW'(DEPTH));
   assign w_rx_pop  = rx_rd && (r_rx_cnt != '0);

   always_ff @(posedge g_clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= input_bus;
   end

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
            2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // TX FIFO: core pushes, device pops.
   assign w_tx_full = (r_tx_cnt == CW'(DEPTH));
   assign w_tx_push = tx_wr && !w_tx_full;

   always_ff @(posedge g_clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
   end

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
            2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   always_comb begin
      w_rx_nxt     = r_rx_st;
      w_rx_push    = 1'b0;
      w_in_ack_nxt = r_in_ack;
      case (r_rx_st)
         RX_IDLE: begin
            if (!w_in_hs_s && !w_rx_full) begin
               w_rx_push    = 1'b1;
               w_in_ack_nxt = 1'b0;
               w_rx_nxt     = RX_ACK;
            end
         end
         RX_ACK: begin
            if (w_in_hs_s || w_rx_tmo) begin
               w_in_ack_nxt = 1'b1;
               w_rx_nxt     = RX_IDLE;
            end
         end
         default: begin
            w_in_ack_nxt = 1'b1;
            w_rx_nxt     = RX_IDLE;
         end
      endcase
   end

   // A timeout in TX_PRES leaves the word in the FIFO so the next request retries it.
   always_comb begin
      w_tx_nxt      = r_tx_st;
      w_tx_pop      = 1'b0;
      w_tx_load     = 1'b0;
      w_out_rdy_nxt = r_out_rdy;
      case (r_tx_st)
         TX_IDLE: begin
            if (!w_out_hs_s && (r_tx_cnt != '0)) begin
               w_tx_load     = 1'b1;
               w_out_rdy_nxt = 1'b0;
               w_tx_nxt      = TX_PRES;
            end
         end
         TX_PRES: begin
            if (!w_out_ack_s) begin
               w_tx_pop      = 1'b1;
               w_out_rdy_nxt = 1'b1;
               w_tx_nxt      = TX_DONE;
            end else if (w_tx_tmo) begin
               w_out_rdy_nxt = 1'b1;
               w_tx_nxt      = TX_IDLE;
            end
         end
         TX_DONE: begin
            if ((w_out_hs_s && w_out_ack_s) || w_tx_tmo) w_tx_nxt = TX_IDLE;
         end
         default: begin
            w_out_rdy_nxt = 1'b1;
            w_tx_nxt      = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_rx_st   <= RX_IDLE;
         r_tx_st   <= TX_IDLE;
         r_in_ack  <= 1'b1;
         r_out_rdy <= 1'b1;
         r_out_bus <= '0;
      end else begin
         r_rx_st   <= w_rx_nxt;
         r_tx_st   <= w_tx_nxt;
         r_in_ack  <= w_in_ack_nxt;
         r_out_rdy <= w_out_rdy_nxt;
         if (w_tx_load) r_out_bus <= r_tx_mem[r_tx_rp];
      end
   end

`ifdef HS_IO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_rx_tmr, r_tx_tmr;
   logic          r_err_rx, r_err_tx;
   logic          w_rx_to_set, w_tx_to_set;

   // Down-counters reload on every state change; terminal count is zero.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_rx_tmr <= '0;
         r_tx_tmr <= '0;
      end else begin
         if (w_rx_nxt != r_rx_st)  r_rx_tmr <= TW'(TIMEOUT_CYC - 1);
         else if (r_rx_tmr != '0)  r_rx_tmr <= r_rx_tmr - TW'(1);
         if (w_tx_nxt != r_tx_st)  r_tx_tmr <= TW'(TIMEOUT_CYC - 1);
         else if (r_tx_tmr != '0)  r_tx_tmr <= r_tx_tmr - TW'(1);
      end
   end

   assign w_rx_tmo = (r_rx_st == RX_ACK) && (r_rx_tmr == '0);
   assign w_tx_tmo = ((r_tx_st == TX_PRES) || (r_tx_st == TX_DONE)) && (r_tx_tmr == '0);

   assign w_rx_to_set = w_rx_tmo && !w_in_hs_s;
   assign w_tx_to_set = w_tx_tmo && ((r_tx_st == TX_PRES) ? w_out_ack_s
                                                          : !(w_out_hs_s && w_out_ack_s));

   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         r_err_rx <= 1'b0;
         r_err_tx <= 1'b0;
      end else if (err_clr) begin
         r_err_rx <= 1'b0;
         r_err_tx <= 1'b0;
      end else begin
         if (w_rx_to_set) r_err_rx <= 1'b1;
         if (w_tx_to_set) r_err_tx <= 1'b1;
      end
   end

   assign err_rx_to = r_err_rx;
   assign err_tx_to = r_err_tx;
`else
   assign w_rx_tmo  = 1'b0;
   assign w_tx_tmo  = 1'b0;
   assign err_rx_to = 1'b0;
   assign err_tx_to = 1'b0;
`endif

   assign in_dev_ack  = r_in_ack;
   assign out_dev_rdy = r_out_rdy;
   assign output_bus  = r_out_bus;
   assign rx_data     = r_rx_mem[r_rx_rp];
   assign rx_empty    = (r_rx_cnt == '0);
   assign rx_count    = r_rx_cnt;
   assign tx_full     = w_tx_full;
   assign tx_count    = r_tx_cnt;

endmodule

// File: tb/tb_hs_io_port.sv
// Directed bench for hs_io_port: core-side table vectors plus hand-written handshake sequences.
// Timeout checks compile in when HS_IO_TIMEOUT_EN is defined.
module tb_hs_io_port;

   logic       g_clk = 1'b0;
   logic       g_clr;
   logic [7:0] input_bus;
   logic       in_dev_hs;
   logic       in_dev_ack;
   logic [7:0] output_bus;
   logic       out_dev_hs;
   logic       out_dev_rdy;
   logic       out_dev_ack;
   logic       rx_rd;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic [2:0] rx_count;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       tx_full;
   logic [2:0] tx_count;
   logic       err_clr;
   logic       err_rx_to;
   logic       err_tx_to;

   int n_tests = 0;
   int n_fail  = 0;

   hs_io_port #(.DATA_W(8), .DEPTH(4), .TIMEOUT_CYC(8)) dut (
      .g_clk(g_clk), .g_clr(g_clr),
      .input_bus(input_bus), .in_dev_hs(in_dev_hs), .in_dev_ack(in_dev_ack),
      .output_bus(output_bus), .out_dev_hs(out_dev_hs), .out_dev_rdy(out_dev_rdy),
      .out_dev_ack(out_dev_ack),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
      .err_clr(err_clr), .err_rx_to(err_rx_to), .err_tx_to(err_tx_to)
   );

   always #5 g_clk = ~g_clk;

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       rd;
      logic [2:0] exp_txc;
      logic       exp_full;
      logic [2:0] exp_rxc;
   } vec_t;

   vec_t vecs [6];

   task automatic step();
      @(posedge g_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic rx_push(input logic [7:0] d);
      input_bus = d;
      in_dev_hs = 1'b0;
      for (int k = 0; k < 12 && in_dev_ack !== 1'b0; k++) step();
      chk("rx_push_ack_low", {31'd0, in_dev_ack}, 32'd0);
      in_dev_hs = 1'b1;
      for (int k = 0; k < 12 && in_dev_ack !== 1'b1; k++) step();
      chk("rx_push_ack_high", {31'd0, in_dev_ack}, 32'd1);
   endtask

   task automatic rx_pop_chk(input logic [7:0] exp);
      chk("rx_data", {24'd0, rx_data}, {24'd0, exp});
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
   endtask

   task automatic tx_drain(input logic [7:0] exp, input logic [2:0] exp_cnt_after);
      out_dev_hs = 1'b0;
      for (int k = 0; k < 12 && out_dev_rdy !== 1'b0; k++) step();
      chk("tx_rdy_low", {31'd0, out_dev_rdy}, 32'd0);
      chk("tx_output_bus", {24'd0, output_bus}, {24'd0, exp});
      out_dev_ack = 1'b0;
      for (int k = 0; k < 12 && out_dev_rdy !== 1'b1; k++) step();
      chk("tx_rdy_high", {31'd0, out_dev_rdy}, 32'd1);
      chk("tx_count_pop", {29'd0, tx_count}, {29'd0, exp_cnt_after});
      out_dev_hs  = 1'b1;
      out_dev_ack = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 3'd0};
      vecs[1] = '{1'b1, 8'h12, 1'b1, 3'd2, 1'b0, 3'd0};
      vecs[2] = '{1'b1, 8'h13, 1'b0, 3'd3, 1'b0, 3'd0};
      vecs[3] = '{1'b1, 8'h14, 1'b0, 3'd4, 1'b1, 3'd0};
      vecs[4] = '{1'b1, 8'h99, 1'b0, 3'd4, 1'b1, 3'd0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 3'd0};

      g_clr = 1'b0; input_bus = 8'h00; in_dev_hs = 1'b1; out_dev_hs = 1'b1;
      out_dev_ack = 1'b1; rx_rd = 1'b0; tx_wr = 1'b0; tx_data = 8'h00; err_clr = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_in_ack", {31'd0, in_dev_ack}, 32'd1);
      chk("rst_out_rdy", {31'd0, out_dev_rdy}, 32'd1);
      chk("rst_output_bus", {24'd0, output_bus}, 32'd0);
      chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
      chk("rst_tx_full", {31'd0, tx_full}, 32'd0);
      chk("rst_counts", {26'd0, rx_count, tx_count}, 32'd0);
      chk("rst_err", {30'd0, err_rx_to, err_tx_to}, 32'd0);

      // Input capture edge timing
      input_bus = 8'h0A;
      g_clr = 1'b1;
      repeat (2) step();
      in_dev_hs = 1'b0;
      step();
      chk("cap_edge0_ack", {31'd0, in_dev_ack}, 32'd1);
      step();
      chk("cap_edge1_ack", {31'd0, in_dev_ack}, 32'd1);
      step();
      chk("cap_edge2_ack", {31'd0, in_dev_ack}, 32'd0);
      chk("cap_rx_count", {29'd0, rx_count}, 32'd1);
      chk("cap_rx_data", {24'd0, rx_data}, 32'h0A);
      in_dev_hs = 1'b1;
      step();
      chk("rel_edge0_ack", {31'd0, in_dev_ack}, 32'd0);
      step();
      chk("rel_edge1_ack", {31'd0, in_dev_ack}, 32'd0);
      step();
      chk("rel_edge2_ack", {31'd0, in_dev_ack}, 32'd1);
      rx_pop_chk(8'h0A);
      chk("rx_empty_after_pop", {31'd0, rx_empty}, 32'd1);

      // RX full: fifth request waits until the core frees a slot
      rx_push(8'h01); rx_push(8'h02); rx_push(8'h03); rx_push(8'h04);
      chk("rx_full_count", {29'd0, rx_count}, 32'd4);
      input_bus = 8'h05;
      in_dev_hs = 1'b0;
      repeat (10) step();
      chk("rx_full_no_ack", {31'd0, in_dev_ack}, 32'd1);
      chk("rx_full_count_hold", {29'd0, rx_count}, 32'd4);
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
      chk("rx_full_pop_count", {29'd0, rx_count}, 32'd3);
      chk("rx_full_deferred_ack", {31'd0, in_dev_ack}, 32'd1);
      step();
      chk("rx_full_late_ack", {31'd0, in_dev_ack}, 32'd0);
      chk("rx_full_refill", {29'd0, rx_count}, 32'd4);
      in_dev_hs = 1'b1;
      for (int k = 0; k < 12 && in_dev_ack !== 1'b1; k++) step();
      rx_pop_chk(8'h02); rx_pop_chk(8'h03); rx_pop_chk(8'h04); rx_pop_chk(8'h05);
      chk("rx_drained", {29'd0, rx_count}, 32'd0);

      // Core-side vectors: TX fill, ignored write on full, rx_rd on empty
      for (int i = 0; i < 6; i++) begin
         tx_wr   = vecs[i].wr;
         tx_data = vecs[i].d;
         rx_rd   = vecs[i].rd;
         step();
         chk($sformatf("vec%0d_tx_count", i), {29'd0, tx_count}, {29'd0, vecs[i].exp_txc});
         chk($sformatf("vec%0d_tx_full", i), {31'd0, tx_full}, {31'd0, vecs[i].exp_full});
         chk($sformatf("vec%0d_rx_count", i), {29'd0, rx_count}, {29'd0, vecs[i].exp_rxc});
      end
      tx_wr = 1'b0; rx_rd = 1'b0;

      // TX wrap
      tx_drain(8'h11, 3'd3);
      tx_drain(8'h12, 3'd2);
      tx_wr = 1'b1; tx_data = 8'h15; step();
      tx_data = 8'h16; step();
      tx_wr = 1'b0;
      chk("tx_wrap_full", {31'd0, tx_full}, 32'd1);
      tx_drain(8'h13, 3'd3);
      tx_drain(8'h14, 3'd2);
      tx_drain(8'h15, 3'd1);
      tx_drain(8'h16, 3'd0);

      // TX request waiting on data
      out_dev_hs = 1'b0;
      repeat (6) step();
      chk("tx_wait_rdy_high", {31'd0, out_dev_rdy}, 32'd1);
      tx_wr = 1'b1; tx_data = 8'hA5;
      step();
      tx_wr = 1'b0;
      chk("tx_wait_rdy_at_wr", {31'd0, out_dev_rdy}, 32'd1);
      step();
      chk("tx_wait_rdy_low", {31'd0, out_dev_rdy}, 32'd0);
      chk("tx_wait_bus", {24'd0, output_bus}, 32'hA5);
      out_dev_ack = 1'b0;
      for (int k = 0; k < 12 && out_dev_rdy !== 1'b1; k++) step();
      chk("tx_wait_pop", {29'd0, tx_count}, 32'd0);
      out_dev_hs = 1'b1; out_dev_ack = 1'b1;
      repeat (4) step();

      // Asynchronous reset in RX_ACK and TX_PRES
      input_bus = 8'h33; in_dev_hs = 1'b0; out_dev_hs = 1'b0;
      for (int k = 0; k < 12 && in_dev_ack !== 1'b0; k++) step();
      chk("mid_rx_ack", {31'd0, in_dev_ack}, 32'd0);
      tx_wr = 1'b1; tx_data = 8'h44;
      step();
      tx_wr = 1'b0;
      for (int k = 0; k < 12 && out_dev_rdy !== 1'b0; k++) step();
      chk("mid_tx_rdy", {31'd0, out_dev_rdy}, 32'd0);
      #2 g_clr = 1'b0;
      #1;
      chk("mid_rst_in_ack", {31'd0, in_dev_ack}, 32'd1);
      chk("mid_rst_out_rdy", {31'd0, out_dev_rdy}, 32'd1);
      chk("mid_rst_counts", {26'd0, rx_count, tx_count}, 32'd0);
      chk("mid_rst_bus", {24'd0, output_bus}, 32'd0);
      in_dev_hs = 1'b1; out_dev_hs = 1'b1;
      repeat (2) step();
      g_clr = 1'b1;
      repeat (3) step();
      chk("post_rst_rx_empty", {31'd0, rx_empty}, 32'd1);

`ifdef HS_IO_TIMEOUT_EN
      // Request held low: ack releases after 8 cycles in RX_ACK
      input_bus = 8'h5A; in_dev_hs = 1'b0;
      for (int k = 0; k < 12 && in_dev_ack !== 1'b0; k++) step();
      chk("to_ack_low", {31'd0, in_dev_ack}, 32'd0);
      repeat (7) step();
      chk("to_ack_still_low", {31'd0, in_dev_ack}, 32'd0);
      chk("to_err_not_yet", {31'd0, err_rx_to}, 32'd0);
      step();
      chk("to_ack_released", {31'd0, in_dev_ack}, 32'd1);
      chk("to_err_set", {31'd0, err_rx_to}, 32'd1);
      in_dev_hs = 1'b1;
      repeat (6) step();
      chk("to_err_sticky", {31'd0, err_rx_to}, 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("to_err_cleared", {31'd0, err_rx_to}, 32'd0);
      chk("to_tx_err", {31'd0, err_tx_to}, 32'd0);
`else
      chk("err_tied_low", {30'd0, err_rx_to, err_tx_to}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
